imem_loader: RTL and testbench

Sequential writer for the instruction memory: receives a byte stream from a host link (UART receiver or debug port), assembles big-endian instruction words and writes them to consecutive memory addresses from 0. Sits between the host-link receiver and the write port of the instruction memory. Holds `busy` high while loading so the top level can keep the CPU in reset until the program image is complete.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 39 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings,
// header length and the bytes-per-word derivation.
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int HDR_LEN = 2;

  function automatic int bytes_per_word(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler. The completed word and the
// word_complete pulse are presented combinationally with the last byte.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [DWIDTH-1:0] word,
  output logic              word_complete
);

  localparam int BPW = bytes_per_word(DWIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DWIDTH-1:0] shreg;
  logic [CW-1:0]     cnt;

  assign word          = (shreg << 8) | DWIDTH'(byte_in);
  assign word_complete = byte_valid && (cnt == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_valid) begin
      shreg <= word;
      cnt   <= word_complete ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory.
// Optional trailing XOR checksum when IMEM_LOADER_CSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_valid may drop at any time and simply stalls the stream.

`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] ST_TAIL = ST_CSUM;
  logic [7:0] csum;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic [2:0]        state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       remaining;
  logic [AWIDTH-1:0] addr;
  logic              accept, data_byte, asm_clear, word_complete, oversize;
  logic [15:0]       len_full;
  logic [DWIDTH-1:0] word;

  assign accept    = rx_valid && rx_ready;
  assign data_byte = accept && (state == ST_DATA);
  assign asm_clear = (state == ST_IDLE) && start;
  assign len_full  = {len_hi, rx_data};
  assign oversize  = 32'(len_full) > (32'd1 << AWIDTH);
  assign dbg_state = state;

  word_assembler #(.DWIDTH(DWIDTH)) u_word_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (asm_clear),
    .byte_valid   (data_byte),
    .byte_in      (rx_data),
    .word         (word),
    .word_complete(word_complete)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (oversize)            state_nxt = ST_DONE;
          else if (len_full == '0) state_nxt = ST_TAIL;
          else                     state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (word_complete && remaining == 16'd1) state_nxt = ST_TAIL;
      ST_CSUM:   if (accept) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_hi    <= '0;
      remaining <= '0;
      addr      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      rx_ready <= (state_nxt == ST_LEN_HI) || (state_nxt == ST_LEN_LO) ||
                  (state_nxt == ST_DATA)   || (state_nxt == ST_CSUM);
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      mem_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err  <= 1'b0;
            addr <= '0;
          end
        end
        ST_LEN_HI: if (accept) len_hi <= rx_data;
        ST_LEN_LO: begin
          if (accept) begin
            remaining <= len_full;
            if (oversize) err <= 1'b1;
          end
        end
        ST_DATA: begin
          if (word_complete) begin
            mem_we    <= 1'b1;
            mem_wdata <= word;
            mem_waddr <= addr;
            addr      <= addr + 1'b1;
            remaining <= remaining - 16'd1;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: if (accept && rx_data != csum) err <= 1'b1;
`endif
        default: ;
      endcase
`ifdef IMEM_LOADER_CSUM_EN
      // Running XOR covers header and data; the checksum byte itself is excluded.
      if (asm_clear)
        csum <= '0;
      else if (accept && state != ST_CSUM)
        csum <= csum ^ rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default parameters); covers the checksum
// variant as well when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 10;
  localparam int W      = AWIDTH + DWIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready, mem_we, busy, done, err;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [2:0]        dbg_state;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         we_cnt   = 0;
  int         we_base;
  logic [7:0] csum_acc = 8'h00;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  imem_loader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && mem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'(mem_waddr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", 64'(mem_waddr), 64'(e[W-1:DWIDTH]));
        check("we_data", 64'(mem_wdata), 64'(e[DWIDTH-1:0]));
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      csum_acc = csum_acc ^ b;
    end
  endtask

  task automatic gap();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h55;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    csum_acc = 8'h00;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic trailer();
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(csum_acc);
`endif
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic push_exp(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    // reset values
    #12;
    check("rst_outputs", 64'({rx_ready, mem_we, busy, done, err}), 64'd0);
    check("rst_waddr", 64'(mem_waddr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", 64'({rx_ready, busy}), 64'd0);

    // two-word load
    do_start();
    check("t1_busy", 64'(busy), 64'd1);
    send_hdr(16'h0002);
    push_exp(10'd0, 32'h3C1D1001);
    push_exp(10'd1, 32'h34080004);
    send_word(32'h3C1D1001);
    send_word(32'h34080004);
    @(negedge clk);
    rx_valid = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    check("t1_we_no_done", 64'({mem_we, done}), 64'b10);
    trailer();
    @(negedge clk);
    rx_valid = 1'b0;
    check("t1_done", 64'(done), 64'd1);
`else
    check("t1_we_and_done", 64'({mem_we, done}), 64'b11);
`endif
    check("t1_err", 64'(err), 64'd0);
    check("t1_ready_low", 64'(rx_ready), 64'd0);
    @(negedge clk);
    check("t1_after", 64'({busy, done}), 64'd0);

    // zero-length load
    we_base = we_cnt;
    do_start();
    send_hdr(16'h0000);
    @(negedge clk);
    rx_valid = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    check("t2_wait_csum", 64'({done, rx_ready}), 64'b01);
    trailer();
    @(negedge clk);
    rx_valid = 1'b0;
`endif
    check("t2_done", 64'(done), 64'd1);
    check("t2_no_we", 64'(we_cnt - we_base), 64'd0);
    @(negedge clk);
    check("t2_busy_fall", 64'({busy, done, err}), 64'd0);

    // oversize count: 0x0401 > 1024
    we_base = we_cnt;
    do_start();
    send_hdr(16'h0401);
    @(negedge clk);
    rx_valid = 1'b0;
    check("t3_done_err", 64'({done, err, busy, rx_ready}), 64'b1110);
    @(negedge clk);
    check("t3_idle_err_sticky", 64'({busy, done, err}), 64'b001);
    check("t3_no_we", 64'(we_cnt - we_base), 64'd0);

    // gapped one-word load, stray start mid-load
    do_start();
    check("t4_err_cleared", 64'(err), 64'd0);
    send_hdr(16'h0001);
    push_exp(10'd0, 32'hDEADBEEF);
    send_byte(8'hDE);
    gap();
    send_byte(8'hAD);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hBE);
    gap();
    send_byte(8'hEF);
    trailer();
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("t4_done");
    check("t4_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    check("t4_start_ignored", 64'({busy, rx_ready, dbg_state}), 64'd0);

    // reset after five data bytes: one word already written
    do_start();
    send_hdr(16'h0002);
    push_exp(10'd0, 32'h11223344);
    send_word(32'h11223344);
    send_byte(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_flags", 64'({rx_ready, mem_we, busy, done, err}), 64'd0);
    check("t5_async_addr_data", 64'({mem_waddr, mem_wdata}), 64'd0);
    check("t5_async_state", 64'(dbg_state), 64'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    send_hdr(16'h0002);
    push_exp(10'd0, 32'hA0A1A2A3);
    push_exp(10'd1, 32'hB0B1B2B3);
    send_word(32'hA0A1A2A3);
    send_word(32'hB0B1B2B3);
    trailer();
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("t5_done");
    check("t5_err", 64'(err), 64'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // checksum: XOR of 00 01 00 00 00 01 is 00
    do_start();
    send_hdr(16'h0001);
    push_exp(10'd0, 32'h00000001);
    send_word(32'h00000001);
    send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("t6_good_done");
    check("t6_good_err", 64'(err), 64'd0);
    do_start();
    send_hdr(16'h0001);
    push_exp(10'd0, 32'h00000001);
    send_word(32'h00000001);
    send_byte(8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("t6_bad_done");
    check("t6_bad_err", 64'(err), 64'd1);
`endif

    // maximum count: addresses 0..1023, back-to-back bytes
    we_base = we_cnt;
    do_start();
    send_hdr(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = (32'(i) * 32'h01000193) ^ 32'hA5A50000;
      push_exp(AWIDTH'(i), w);
      send_word(w);
    end
    trailer();
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("t7_done");
    check("t7_err", 64'(err), 64'd0);
    check("t7_writes", 64'(we_cnt - we_base), 64'd1024);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
